mem_pattern_seq: RTL and testbench



---
 rtl/mem_pattern_pkg.sv | 29 ++
 rtl/mem_pattern_cmp.sv | 60 ++++++
 rtl/mem_pattern_seq.sv | 141 ++++++++++++++
 tb/tb_mem_pattern_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pattern_pkg.sv
// Shared types and the per-address test pattern for the memory pattern sequencer.
package mem_pattern_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] FEED = 16'hfeed;
    localparam logic [15:0] FACE = 16'hface;

    // Widest data word the pattern helper can build; callers truncate to their WIDTH.
    localparam int PAT_MAX_W = 1024;

    // Address byte (inverted for FACE) in the top 8 bits of a width-bit word, constant zero-extended below.
    function automatic logic [PAT_MAX_W-1:0] pattern(input logic [7:0] addr_byte,
                                                     input logic       sel,
                                                     input int unsigned width);
        logic [PAT_MAX_W-1:0] tag;
        logic [PAT_MAX_W-1:0] fill;
        tag  = PAT_MAX_W'(sel ? ~addr_byte : addr_byte);
        fill = PAT_MAX_W'(sel ? FACE : FEED);
        return (tag << (width - 32'd8)) | fill;
    endfunction

endpackage

// File: rtl/mem_pattern_cmp.sv
// Registered read-compare stage: pairs each returned word with the address that was read
// one cycle earlier, and keeps the saturating mismatch count and first failing address.
module mem_pattern_cmp
    import mem_pattern_pkg::*;
#(
    parameter int WIDTH = 78,
    parameter int AW    = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             flush,
    input  logic             rd_valid,
    input  logic [AW-1:0]    rd_addr,
    input  logic             sel,
    input  logic [WIDTH-1:0] rdata,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [AW-1:0]    first_err_addr
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic             valid_r;
    logic [AW-1:0]    addr_r;
    logic [WIDTH-1:0] expected_s;

    assign expected_s = WIDTH'(pattern(8'(addr_r), sel, 32'(WIDTH)));
    assign mismatch   = valid_r && (rdata != expected_s);

    // Compare pipeline and error bookkeeping; a flush drops the word currently being compared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r        <= 1'b0;
            addr_r         <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (clear) begin
            valid_r        <= 1'b0;
            addr_r         <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= rd_valid;
            addr_r  <= rd_addr;
            if (mismatch) begin
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (err_count == '0) begin
                    first_err_addr <= addr_r;
                end
            end
        end
    end

endmodule

// File: rtl/mem_pattern_seq.sv
// Memory pattern sequencer: writes a per-address pattern to every word of a single-port
// memory, reads it all back, and reports pass/fail, error count and first failing address.
module mem_pattern_seq
    import mem_pattern_pkg::*;
#(
    parameter int DEPTH = 6,
    parameter int WIDTH = 78,
    parameter int AW    = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pattern_sel,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [AW-1:0]    first_err_addr,
    output logic             mem_we,
    output logic             mem_re,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state_r;
    logic             sel_r;
    logic             accept_s;
    logic             flush_s;
    logic             last_s;
    logic             mismatch_s;
    logic [AW-1:0]    next_addr_s;
    logic [WIDTH-1:0] first_pat_s;
    logic [WIDTH-1:0] next_pat_s;

    assign accept_s    = (state_r == ST_IDLE) && start && !abort;
    assign flush_s     = abort && (state_r != ST_IDLE);
    assign last_s      = (mem_addr == LAST_ADDR);
    assign next_addr_s = mem_addr + AW'(1);
    assign first_pat_s = WIDTH'(pattern(8'd0, pattern_sel, 32'(WIDTH)));
    assign next_pat_s  = WIDTH'(pattern(8'(next_addr_s), sel_r, 32'(WIDTH)));

    mem_pattern_cmp #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .ERR_W (ERR_W)
    ) u_cmp (
        .clk            (clk),
        .rst            (rst),
        .clear          (accept_s),
        .flush          (flush_s),
        .rd_valid       (mem_re),
        .rd_addr        (mem_addr),
        .sel            (sel_r),
        .rdata          (mem_rdata),
        .mismatch       (mismatch_s),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    // Sequencer FSM with registered strobes, address, data and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            sel_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            if (flush_s) begin
                state_r  <= ST_IDLE;
                busy     <= 1'b0;
                pass     <= 1'b0;
                mem_we   <= 1'b0;
                mem_re   <= 1'b0;
                mem_addr <= '0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s) begin
                            state_r   <= ST_WRITE;
                            sel_r     <= pattern_sel;
                            busy      <= 1'b1;
                            pass      <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= '0;
                            mem_wdata <= first_pat_s;
                        end
                    end
                    ST_WRITE: begin
                        if (last_s) begin
                            state_r  <= ST_READ;
                            mem_we   <= 1'b0;
                            mem_re   <= 1'b1;
                            mem_addr <= '0;
                        end else begin
                            mem_addr  <= next_addr_s;
                            mem_wdata <= next_pat_s;
                        end
                    end
                    ST_READ: begin
                        if (last_s) begin
                            state_r  <= ST_CHECK;
                            mem_re   <= 1'b0;
                            mem_addr <= '0;
                        end else begin
                            mem_addr <= next_addr_s;
                        end
                    end
                    ST_CHECK: begin
                        // The last word is still being compared, so fold its result into pass.
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_count == '0) && !mismatch_s;
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        busy     <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_re   <= 1'b0;
                        mem_addr <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_pattern_seq.sv
// Self-checking bench for mem_pattern_seq: strobe scoreboard against a 1-cycle memory model.
module tb_mem_pattern_seq;

    localparam int DEPTH = 6;
    localparam int WIDTH = 78;
    localparam int AW    = 8;
    localparam int ERR_W = 8;
    localparam int DONE_CYC = 2 * DEPTH + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             pattern_sel = 1'b0;
    logic             busy, done, pass;
    logic [ERR_W-1:0] err_count;
    logic [AW-1:0]    first_err_addr;
    logic             mem_we, mem_re;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata, mem_rdata;

    logic             s_start = 1'b0;
    logic             s_busy, s_done, s_pass, s_we, s_re;
    logic [1:0]       s_err;
    logic [AW-1:0]    s_first, s_addr;
    logic [WIDTH-1:0] s_wdata, s_rdata;

    typedef struct {
        logic             wr;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } txn_t;
    txn_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int fault_mode = 0;
    int done_cyc, done_cnt;
    logic busy_h [0:63];
    logic we_h   [0:63];
    logic [WIDTH-1:0] mem_model [0:255];
    logic [WIDTH-1:0] flip;

    mem_pattern_seq #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern_sel(pattern_sel),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_pattern_seq #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .abort(1'b0), .pattern_sel(1'b0),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
        .first_err_addr(s_first), .mem_we(s_we), .mem_re(s_re),
        .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    assign s_rdata = '0;
    assign flip = (fault_mode == 1 && mem_addr == 8'd3) ? WIDTH'(1) : '0;

    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem_model[mem_addr] ^ flip;
    end

    function automatic logic [WIDTH-1:0] exp_pat(input int a, input logic sel);
        logic [WIDTH-1:0] v;
        logic [7:0] b;
        b = a[7:0];
        v = '0;
        v[15:0] = sel ? 16'hface : 16'hfeed;
        v[WIDTH-1 -: 8] = sel ? ~b : b;
        return v;
    endfunction

    // Strobe monitor: every strobe must match the next scoreboard entry and stay in range.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (!rst && (mem_we || mem_re)) begin
                n_vec++;
                if (mem_we && mem_re) begin
                    n_err++; $display("FAIL strobe_overlap got we=%0b re=%0b required not both", mem_we, mem_re);
                end
                n_vec++;
                if (mem_addr >= AW'(DEPTH)) begin
                    n_err++; $display("FAIL addr_range got=%0d required <%0d", mem_addr, DEPTH);
                end
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL unexpected_strobe we=%0b addr=%0d", mem_we, mem_addr);
                end else begin
                    t = exp_q.pop_front();
                    if ({mem_we, mem_addr} !== {t.wr, t.addr}) begin
                        n_err++; $display("FAIL strobe_seq got we=%0b addr=%0d required we=%0b addr=%0d", mem_we, mem_addr, t.wr, t.addr);
                    end else if (t.wr && mem_wdata !== t.data) begin
                        n_err++; $display("FAIL wdata addr=%0d got=%h required=%h", mem_addr, mem_wdata, t.data);
                    end
                end
            end
        end
    end

    task automatic launch(input logic sel);
        for (int a = 0; a < DEPTH; a++) exp_q.push_back('{1'b1, AW'(a), exp_pat(a, sel)});
        for (int a = 0; a < DEPTH; a++) exp_q.push_back('{1'b0, AW'(a), {WIDTH{1'b0}}});
        @(negedge clk);
        start = 1'b1;
        pattern_sel = sel;
        @(posedge clk);
        #1;
        start = 1'b0;
        pattern_sel = ~sel;
    endtask

    task automatic run_cycles(input int max, input int abort_at, input logic [63:0] start_mask);
        done_cyc = -1;
        done_cnt = 0;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            busy_h[k] = busy;
            we_h[k]   = mem_we;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            abort = (k == abort_at);
            start = start_mask[k];
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, pass, mem_we, mem_re, err_count, first_err_addr, mem_addr} !== '0 || mem_wdata !== '0) begin
            n_err++; $display("FAIL reset_outputs got busy=%0b done=%0b pass=%0b err=%0d required all 0", busy, done, pass, err_count);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done, mem_we, mem_re} !== 4'b0000) begin
            n_err++; $display("FAIL idle_after_reset got busy=%0b done=%0b we=%0b re=%0b required 0", busy, done, mem_we, mem_re);
        end
    endtask

    task automatic test_feed_pass;
        launch(1'b0);
        run_cycles(20, 0, 64'd0);
        n_vec++;
        if (done_cyc !== DONE_CYC) begin n_err++; $display("FAIL feed_done_cycle got=%0d required=%0d", done_cyc, DONE_CYC); end
        n_vec++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL feed_done_count got=%0d required=1", done_cnt); end
        n_vec++;
        if ({busy_h[1], busy_h[2*DEPTH+1], busy_h[DONE_CYC]} !== 3'b110) begin
            n_err++; $display("FAIL feed_busy got=%b required=110", {busy_h[1], busy_h[2*DEPTH+1], busy_h[DONE_CYC]});
        end
        n_vec++;
        if ({we_h[DEPTH], we_h[DEPTH+1]} !== 2'b10) begin
            n_err++; $display("FAIL feed_we_window got=%b required=10", {we_h[DEPTH], we_h[DEPTH+1]});
        end
        n_vec++;
        if (pass !== 1'b1 || err_count !== 8'd0) begin
            n_err++; $display("FAIL feed_result got pass=%0b err=%0d required pass=1 err=0", pass, err_count);
        end
        n_vec++;
        if (exp_q.size() !== 0) begin n_err++; $display("FAIL feed_strobes_left got=%0d required=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_face_fault;
        fault_mode = 1;
        launch(1'b1);
        run_cycles(20, 0, 64'd0);
        fault_mode = 0;
        n_vec++;
        if (done_cyc !== DONE_CYC) begin n_err++; $display("FAIL fault_done_cycle got=%0d required=%0d", done_cyc, DONE_CYC); end
        n_vec++;
        if (pass !== 1'b0 || err_count !== 8'd1) begin
            n_err++; $display("FAIL fault_result got pass=%0b err=%0d required pass=0 err=1", pass, err_count);
        end
        n_vec++;
        if (first_err_addr !== 8'd3) begin n_err++; $display("FAIL fault_first_addr got=%0d required=3", first_err_addr); end
        n_vec++;
        if (exp_q.size() !== 0) begin n_err++; $display("FAIL fault_strobes_left got=%0d required=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_saturate;
        int seen;
        seen = -1;
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (s_done && seen < 0) seen = k;
        end
        n_vec++;
        if (seen !== DONE_CYC) begin n_err++; $display("FAIL sat_done_cycle got=%0d required=%0d", seen, DONE_CYC); end
        n_vec++;
        if (s_err !== 2'd3 || s_pass !== 1'b0) begin
            n_err++; $display("FAIL sat_result got err=%0d pass=%0b required err=3 pass=0", s_err, s_pass);
        end
        n_vec++;
        if (s_first !== 8'd0) begin n_err++; $display("FAIL sat_first_addr got=%0d required=0", s_first); end
    endtask

    task automatic test_abort;
        launch(1'b0);
        run_cycles(20, 3, 64'd0);
        n_vec++;
        if ({busy_h[3], busy_h[4], we_h[4]} !== 3'b100) begin
            n_err++; $display("FAIL abort_idle got=%b required=100", {busy_h[3], busy_h[4], we_h[4]});
        end
        n_vec++;
        if (done_cnt !== 0) begin n_err++; $display("FAIL abort_done_count got=%0d required=0", done_cnt); end
        n_vec++;
        if (pass !== 1'b0 || err_count !== 8'd0) begin
            n_err++; $display("FAIL abort_status got pass=%0b err=%0d required pass=0 err=0", pass, err_count);
        end
        n_vec++;
        if (exp_q.size() !== 2 * DEPTH - 3) begin n_err++; $display("FAIL abort_strobes_left got=%0d required=%0d", exp_q.size(), 2 * DEPTH - 3); end
        exp_q.delete();
        launch(1'b0);
        run_cycles(20, 0, 64'd0);
        n_vec++;
        if (done_cyc !== DONE_CYC || pass !== 1'b1) begin
            n_err++; $display("FAIL abort_rerun got done_cyc=%0d pass=%0b required %0d/1", done_cyc, pass, DONE_CYC);
        end
        exp_q.delete();
    endtask

    task automatic test_start_ignored;
        logic [63:0] mask;
        mask = '0;
        mask[2] = 1'b1;
        mask[8] = 1'b1;
        mask[DONE_CYC] = 1'b1;
        launch(1'b1);
        run_cycles(20, 0, mask);
        n_vec++;
        if (done_cnt !== 1 || done_cyc !== DONE_CYC) begin
            n_err++; $display("FAIL ignore_done got cnt=%0d cyc=%0d required 1/%0d", done_cnt, done_cyc, DONE_CYC);
        end
        n_vec++;
        if (busy_h[DONE_CYC+2] !== 1'b0) begin n_err++; $display("FAIL ignore_restart got busy=%0b required=0", busy_h[DONE_CYC+2]); end
        n_vec++;
        if (exp_q.size() !== 0) begin n_err++; $display("FAIL ignore_strobes_left got=%0d required=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_async_reset;
        launch(1'b0);
        run_cycles(9, 0, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, pass, mem_we, mem_re, err_count, first_err_addr, mem_addr} !== '0 || mem_wdata !== '0) begin
            n_err++; $display("FAIL async_reset got busy=%0b re=%0b addr=%0d required all 0", busy, mem_re, mem_addr);
        end
        n_vec++;
        if (exp_q.size() !== 2 * DEPTH - 9) begin n_err++; $display("FAIL async_strobes_left got=%0d required=%0d", exp_q.size(), 2 * DEPTH - 9); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, mem_we, mem_re} !== 3'b000) begin
            n_err++; $display("FAIL async_hold got busy=%0b we=%0b re=%0b required 0", busy, mem_we, mem_re);
        end
        rst = 1'b0;
        launch(1'b1);
        run_cycles(20, 0, 64'd0);
        n_vec++;
        if (done_cyc !== DONE_CYC || pass !== 1'b1 || err_count !== 8'd0) begin
            n_err++; $display("FAIL async_rerun got cyc=%0d pass=%0b err=%0d required %0d/1/0", done_cyc, pass, err_count, DONE_CYC);
        end
        n_vec++;
        if (exp_q.size() !== 0) begin n_err++; $display("FAIL async_strobes_after got=%0d required=0", exp_q.size()); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_feed_pass();
        test_face_fault();
        test_saturate();
        test_abort();
        test_start_ignored();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
